// File: rtl/laser_cover_opt.sv
// Laser coverage optimiser.
// Loads NPTS grid points, then places NCIRC fixed-radius circles by coordinate
// descent. Each circle in turn sweeps every grid position while the other
// circles stay put, and keeps the raster-first position that covers the most
// points. Passes repeat until a pass moves no circle or MAX_PASS is reached.
//
// Handshake: a point is taken on every rising edge where IN_VALID is high
// while the engine is in IDLE or LOAD. There is no ready; IN_VALID is simply
// ignored while a job is being optimised. DONE is a one-cycle pulse, and
// C_X/C_Y/COVER are final in that cycle and hold until the next job starts.
module laser_cover_opt #(
  parameter int COORD_W  = 4,
  parameter int NPTS     = 40,
  parameter int NCIRC    = 2,
  parameter int RADIUS   = 4,
  parameter int MAX_PASS = 8
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         IN_VALID,
  input  logic [COORD_W-1:0]           X,
  input  logic [COORD_W-1:0]           Y,
  output logic [NCIRC*COORD_W-1:0]     C_X,
  output logic [NCIRC*COORD_W-1:0]     C_Y,
  output logic [$clog2(NPTS+1)-1:0]    COVER,
  output logic                         BUSY,
  output logic                         DONE
);

  localparam int CW = $clog2(NPTS + 1);
  localparam int IW = $clog2(NPTS);
  localparam int KW = (NCIRC > 1) ? $clog2(NCIRC) : 1;
  localparam int PW = $clog2(MAX_PASS + 1);
  localparam logic [COORD_W-1:0] CMAX      = '1;
  localparam logic [IW-1:0]      LAST_IDX  = IW'(NPTS - 1);
  localparam logic [KW-1:0]      LAST_K    = KW'(NCIRC - 1);
  localparam logic [PW-1:0]      LAST_PASS = PW'(MAX_PASS - 1);
  localparam logic [31:0]        R2        = 32'(RADIUS * RADIUS);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_EVAL, S_CMP, S_NEXTC, S_FIN
  } state_t;

  state_t state, state_n;

  logic [COORD_W-1:0] px [NPTS];
  logic [COORD_W-1:0] py [NPTS];

  logic [IW-1:0]      idx;
  logic [IW-1:0]      wr_idx;
  logic [COORD_W-1:0] cand_x, cand_y;
  logic [COORD_W-1:0] best_x, best_y;
  logic [CW-1:0]      acc, best;
  logic [KW-1:0]      k;
  logic [PW-1:0]      pass_cnt;
  logic               changed;

  logic               cov;
  logic [COORD_W-1:0] cur_x, cur_y;
  logic               moved;
  logic               first_cand, last_cand, last_k, stop;
  logic               take;

  // Inclusive circle test on exact-width squared distance.
  function automatic logic in_circle(input logic [COORD_W-1:0] ax, input logic [COORD_W-1:0] ay,
                                     input logic [COORD_W-1:0] bx, input logic [COORD_W-1:0] by);
    logic [COORD_W-1:0]   dx, dy;
    logic [2*COORD_W-1:0] sx, sy;
    logic [2*COORD_W:0]   s;
    dx = (ax >= bx) ? ax - bx : bx - ax;
    dy = (ay >= by) ? ay - by : by - ay;
    sx = {{COORD_W{1'b0}}, dx} * {{COORD_W{1'b0}}, dx};
    sy = {{COORD_W{1'b0}}, dy} * {{COORD_W{1'b0}}, dy};
    s  = {1'b0, sx} + {1'b0, sy};
    return (32'(s) <= R2);
  endfunction

  assign BUSY   = (state != S_IDLE);
  assign DONE   = (state == S_FIN);
  assign take   = IN_VALID && ((state == S_IDLE) || (state == S_LOAD));
  assign wr_idx = (state == S_IDLE) ? '0 : idx;

  // Coverage of the current point and the position of the circle being moved.
  always_comb begin
    cov   = in_circle(px[idx], py[idx], cand_x, cand_y);
    cur_x = '0;
    cur_y = '0;
    for (int j = 0; j < NCIRC; j++) begin
      if (j == int'(k)) begin
        cur_x = C_X[j*COORD_W +: COORD_W];
        cur_y = C_Y[j*COORD_W +: COORD_W];
      end else if (in_circle(px[idx], py[idx], C_X[j*COORD_W +: COORD_W],
                             C_Y[j*COORD_W +: COORD_W])) begin
        cov = 1'b1;
      end
    end
    moved      = (best_x != cur_x) || (best_y != cur_y);
    first_cand = (cand_x == '0) && (cand_y == '0);
    last_cand  = (cand_x == CMAX) && (cand_y == CMAX);
    last_k     = (k == LAST_K);
    stop       = last_k && (!(changed || moved) || (pass_cnt == LAST_PASS));
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (IN_VALID) state_n = S_LOAD;
      S_LOAD:  if (IN_VALID && (idx == LAST_IDX)) state_n = S_EVAL;
      S_EVAL:  if (idx == LAST_IDX) state_n = S_CMP;
      S_CMP:   state_n = last_cand ? S_NEXTC : S_EVAL;
      S_NEXTC: state_n = stop ? S_FIN : S_EVAL;
      S_FIN:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Point memory; no reset needed since a job always overwrites every entry.
  always_ff @(posedge CLK) begin
    if (take) begin
      px[wr_idx] <= X;
      py[wr_idx] <= Y;
    end
  end

  // Datapath: load counter, candidate scan, best tracking, circle update.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      C_X      <= '0;
      C_Y      <= '0;
      COVER    <= '0;
      idx      <= '0;
      cand_x   <= '0;
      cand_y   <= '0;
      best_x   <= '0;
      best_y   <= '0;
      acc      <= '0;
      best     <= '0;
      k        <= '0;
      pass_cnt <= '0;
      changed  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (IN_VALID) begin
            C_X      <= '0;
            C_Y      <= '0;
            COVER    <= '0;
            idx      <= IW'(1);
            pass_cnt <= '0;
            changed  <= 1'b0;
            k        <= '0;
          end
        end
        S_LOAD: begin
          if (IN_VALID) begin
            if (idx == LAST_IDX) begin
              idx    <= '0;
              cand_x <= '0;
              cand_y <= '0;
              acc    <= '0;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        S_EVAL: begin
          acc <= acc + CW'(cov);
          idx <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
        end
        S_CMP: begin
          if (first_cand || (acc > best)) begin
            best   <= acc;
            best_x <= cand_x;
            best_y <= cand_y;
          end
          acc <= '0;
          // Raster order, x fastest; wraps to (0,0) ready for the next circle.
          if (cand_x == CMAX) begin
            cand_x <= '0;
            cand_y <= cand_y + COORD_W'(1);
          end else begin
            cand_x <= cand_x + COORD_W'(1);
          end
        end
        S_NEXTC: begin
          for (int j = 0; j < NCIRC; j++) begin
            if ((j == int'(k)) && moved) begin
              C_X[j*COORD_W +: COORD_W] <= best_x;
              C_Y[j*COORD_W +: COORD_W] <= best_y;
            end
          end
          COVER <= best;
          acc   <= '0;
          idx   <= '0;
          if (last_k) begin
            k        <= '0;
            pass_cnt <= pass_cnt + PW'(1);
            changed  <= 1'b0;
          end else begin
            k       <= k + KW'(1);
            changed <= changed || moved;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_laser_cover_opt.sv
// Bench for laser_cover_opt. One full-size instance runs the default job;
// three 8x8-grid instances (8 points, radius 2) cover the remaining behaviour
// at a fraction of the cycle cost. Per-circle time on the small grid is
// 64*9+1 = 577 cycles; on the default grid 256*41+1 = 10497 cycles.
module tb_laser_cover_opt;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Full-size instance (defaults).
  logic       vld_a = 1'b0;
  logic [3:0] xa = '0, ya = '0;
  logic [7:0] cx_a, cy_a;
  logic [5:0] cov_a;
  logic       busy_a, done_a;

  // Small instances share the point bus.
  logic       vld_b = 1'b0, vld_c = 1'b0, vld_d = 1'b0;
  logic [2:0] xs = '0, ys = '0;
  logic [5:0] cx_b, cy_b, cx_d, cy_d;
  logic [2:0] cx_c, cy_c;
  logic [3:0] cov_b, cov_c, cov_d;
  logic       busy_b, done_b, busy_c, done_c, busy_d, done_d;

  laser_cover_opt dut_a (
    .CLK(clk), .RST(rst), .IN_VALID(vld_a), .X(xa), .Y(ya),
    .C_X(cx_a), .C_Y(cy_a), .COVER(cov_a), .BUSY(busy_a), .DONE(done_a)
  );

  laser_cover_opt #(.COORD_W(3), .NPTS(8), .NCIRC(2), .RADIUS(2), .MAX_PASS(8)) dut_b (
    .CLK(clk), .RST(rst), .IN_VALID(vld_b), .X(xs), .Y(ys),
    .C_X(cx_b), .C_Y(cy_b), .COVER(cov_b), .BUSY(busy_b), .DONE(done_b)
  );

  laser_cover_opt #(.COORD_W(3), .NPTS(8), .NCIRC(1), .RADIUS(2), .MAX_PASS(8)) dut_c (
    .CLK(clk), .RST(rst), .IN_VALID(vld_c), .X(xs), .Y(ys),
    .C_X(cx_c), .C_Y(cy_c), .COVER(cov_c), .BUSY(busy_c), .DONE(done_c)
  );

  laser_cover_opt #(.COORD_W(3), .NPTS(8), .NCIRC(2), .RADIUS(2), .MAX_PASS(1)) dut_d (
    .CLK(clk), .RST(rst), .IN_VALID(vld_d), .X(xs), .Y(ys),
    .C_X(cx_d), .C_Y(cy_d), .COVER(cov_d), .BUSY(busy_d), .DONE(done_d)
  );

  // Expected job result; start is the cycle stamp of the last accepted point.
  typedef struct packed {
    logic [7:0]  cx;
    logic [7:0]  cy;
    logic [7:0]  cov;
    logic [31:0] lat;
    logic [31:0] start;
  } exp_t;

  exp_t exp_q_a[$], exp_q_b[$], exp_q_c[$], exp_q_d[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [2:0] ps_x [8];
  logic [2:0] ps_y [8];
  int         m_cx [2];
  int         m_cy [2];
  int         m_cov;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  task automatic job_check(input string tag, input exp_t e, input logic [31:0] cx,
                           input logic [31:0] cy, input logic [31:0] cov);
    chk({tag, "_cx"}, cx, 32'(e.cx));
    chk({tag, "_cy"}, cy, 32'(e.cy));
    chk({tag, "_cover"}, cov, 32'(e.cov));
    chk({tag, "_latency"}, 32'(cyc) - e.start + 32'd1, e.lat);
  endtask

  task automatic stray_done(input string tag);
    n_cmp++;
    n_fail++;
    $display("FAIL %s_unexpected_done: got DONE, want none", tag);
  endtask

  // Monitors: one per instance, compare on every DONE pulse.
  always @(negedge clk) if (done_a === 1'b1) begin
    if (exp_q_a.size() == 0) stray_done("dut_a");
    else job_check("dut_a", exp_q_a.pop_front(), 32'(cx_a), 32'(cy_a), 32'(cov_a));
  end
  always @(negedge clk) if (done_b === 1'b1) begin
    if (exp_q_b.size() == 0) stray_done("dut_b");
    else job_check("dut_b", exp_q_b.pop_front(), 32'(cx_b), 32'(cy_b), 32'(cov_b));
  end
  always @(negedge clk) if (done_c === 1'b1) begin
    if (exp_q_c.size() == 0) stray_done("dut_c");
    else job_check("dut_c", exp_q_c.pop_front(), 32'(cx_c), 32'(cy_c), 32'(cov_c));
  end
  always @(negedge clk) if (done_d === 1'b1) begin
    if (exp_q_d.size() == 0) stray_done("dut_d");
    else job_check("dut_d", exp_q_d.pop_front(), 32'(cx_d), 32'(cy_d), 32'(cov_d));
  end

  function automatic exp_t mk(input int cx, input int cy, input int cov, input int lat);
    exp_t e;
    e.cx    = 8'(cx);
    e.cy    = 8'(cy);
    e.cov   = 8'(cov);
    e.lat   = 32'(lat);
    e.start = '0;
    return e;
  endfunction

  function automatic int qsize(input int which);
    case (which)
      0:       return exp_q_a.size();
      1:       return exp_q_b.size();
      2:       return exp_q_c.size();
      default: return exp_q_d.size();
    endcase
  endfunction

  task automatic set_vld_s(input int which, input logic v);
    case (which)
      1:       vld_b = v;
      2:       vld_c = v;
      default: vld_d = v;
    endcase
  endtask

  task automatic push_s(input int which, input exp_t e);
    case (which)
      1:       exp_q_b.push_back(e);
      2:       exp_q_c.push_back(e);
      default: exp_q_d.push_back(e);
    endcase
  endtask

  task automatic set_pt(input int i, input int x, input int y);
    ps_x[i] = 3'(x);
    ps_y[i] = 3'(y);
  endtask

  // Drive the 8 points in ps_x/ps_y to a small instance; gap inserts idle cycles.
  task automatic drive_s(input int which, input int gap, input int push, input exp_t e);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      xs = ps_x[i];
      ys = ps_y[i];
      set_vld_s(which, 1'b1);
      if ((gap != 0) || (i == 7)) begin
        @(negedge clk);
        set_vld_s(which, 1'b0);
      end
    end
    e.start = 32'(cyc);
    if (push != 0) push_s(which, e);
  endtask

  // Drive 40 copies of one point to the full-size instance.
  task automatic drive_a(input logic [3:0] px, input logic [3:0] py, input int gap, input exp_t e);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      xa    = px;
      ya    = py;
      vld_a = 1'b1;
      if ((gap != 0) || (i == 39)) begin
        @(negedge clk);
        vld_a = 1'b0;
      end
    end
    e.start = 32'(cyc);
    exp_q_a.push_back(e);
  endtask

  task automatic wait_jobs(input int which, input int budget, input string name);
    int n = 0;
    while ((qsize(which) != 0) && (n < budget)) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(name, (qsize(which) == 0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  function automatic bit inr(input int px, input int py, input int cx, input int cy);
    return ((px - cx) * (px - cx) + (py - cy) * (py - cy)) <= 4;
  endfunction

  // One descent pass on the 8x8 grid, radius 2, two circles starting at (0,0).
  function automatic void model_one_pass();
    m_cx[0] = 0; m_cx[1] = 0;
    m_cy[0] = 0; m_cy[1] = 0;
    m_cov = 0;
    for (int k = 0; k < 2; k++) begin
      int best = -1;
      int bx = 0;
      int by = 0;
      for (int y = 0; y < 8; y++) begin
        for (int x = 0; x < 8; x++) begin
          int cnt = 0;
          for (int i = 0; i < 8; i++) begin
            bit c;
            c = inr(int'(ps_x[i]), int'(ps_y[i]), x, y);
            for (int j = 0; j < 2; j++)
              if ((j != k) && inr(int'(ps_x[i]), int'(ps_y[i]), m_cx[j], m_cy[j])) c = 1'b1;
            if (c) cnt++;
          end
          if (cnt > best) begin
            best = cnt;
            bx   = x;
            by   = y;
          end
        end
      end
      m_cx[k] = bx;
      m_cy[k] = by;
      m_cov   = best;
    end
  endfunction

  initial begin
    // Reset values, sampled while reset is held.
    repeat (3) @(negedge clk);
    chk("rst_cx_a", 32'(cx_a), 0);
    chk("rst_cy_a", 32'(cy_a), 0);
    chk("rst_cover_a", 32'(cov_a), 0);
    chk("rst_busy_a", 32'(busy_a), 0);
    chk("rst_done_a", 32'(done_a), 0);
    chk("rst_busy_b", 32'(busy_b), 0);
    rst = 1'b0;
    @(negedge clk);

    // Two clusters: C0 -> (6,4) first raster hit of (6,6); C1 stays (0,0) and
    // covers (1,1). Two passes. C_X = {0,6}=6, C_Y = {0,4}=4, COVER 8.
    for (int i = 0; i < 4; i++) set_pt(i, 1, 1);
    for (int i = 4; i < 8; i++) set_pt(i, 6, 6);
    drive_s(1, 0, 1, mk(6, 4, 8, 4 * 577 + 1));
    chk("busy_b_running", 32'(busy_b), 1);
    wait_jobs(1, 3000, "b_cluster_done");
    @(negedge clk);
    chk("busy_b_after_done", 32'(busy_b), 0);
    chk("done_b_one_pulse", 32'(done_b), 0);

    // Same clusters, reordered, loaded with gaps and with IN_VALID noise during EVAL.
    for (int i = 0; i < 4; i++) set_pt(i, 6, 6);
    for (int i = 4; i < 8; i++) set_pt(i, 1, 1);
    drive_s(1, 1, 1, mk(6, 4, 8, 4 * 577 + 1));
    repeat (12) begin
      @(negedge clk);
      xs    = 3'd3;
      ys    = 3'd3;
      vld_b = ~vld_b;
    end
    vld_b = 1'b0;
    wait_jobs(1, 3000, "b_gap_done");

    // Reset mid-job after circle 0 of pass 1 has moved.
    for (int i = 0; i < 4; i++) set_pt(i, 1, 1);
    for (int i = 4; i < 8; i++) set_pt(i, 6, 6);
    drive_s(1, 0, 0, mk(0, 0, 0, 0));
    repeat (600) @(negedge clk);
    chk("mid_cx_b", 32'(cx_b), 6);
    chk("mid_cy_b", 32'(cy_b), 4);
    chk("mid_cover_b", 32'(cov_b), 8);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_cx_b", 32'(cx_b), 0);
    chk("rst_mid_cy_b", 32'(cy_b), 0);
    chk("rst_mid_cover_b", 32'(cov_b), 0);
    chk("rst_mid_busy_b", 32'(busy_b), 0);
    rst = 1'b0;
    @(negedge clk);
    drive_s(1, 0, 1, mk(6, 4, 8, 4 * 577 + 1));
    wait_jobs(1, 3000, "b_after_rst_done");

    // Radius edge, one circle: (2,0),(0,2) plus six at (7,7) -> C0 (7,5), COVER 6.
    set_pt(0, 2, 0);
    set_pt(1, 0, 2);
    for (int i = 2; i < 8; i++) set_pt(i, 7, 7);
    drive_s(2, 0, 1, mk(7, 5, 6, 2 * 577 + 1));
    wait_jobs(2, 2000, "c_edge_done");

    // Exactly radius 2 from (0,0) is covered: stays at (0,0), one pass.
    for (int i = 0; i < 8; i++) set_pt(i, 2, 0);
    drive_s(2, 0, 1, mk(0, 0, 8, 577 + 1));
    wait_jobs(2, 1000, "c_inclusive_done");

    // MAX_PASS=1 with spread random points against a one-pass model.
    for (int i = 0; i < 8; i++) set_pt(i, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    model_one_pass();
    drive_s(3, 0, 1, mk(m_cx[1] * 8 + m_cx[0], m_cy[1] * 8 + m_cy[0], m_cov, 2 * 577 + 1));
    wait_jobs(3, 2000, "d_one_pass_done");

    // Default instance: 40 x (7,9) with gaps -> C0 (7,5), C1 (0,0), COVER 40,
    // two passes. IN_VALID noise at (0,0) during EVAL must not alter points.
    drive_a(4'd7, 4'd9, 1, mk(7, 5, 40, 4 * 10497 + 1));
    repeat (20) begin
      @(negedge clk);
      xa    = 4'd0;
      ya    = 4'd0;
      vld_a = ~vld_a;
    end
    vld_a = 1'b0;
    wait_jobs(0, 45000, "a_default_done");
    @(negedge clk);
    chk("busy_a_after_done", 32'(busy_a), 0);
    chk("done_a_one_pulse", 32'(done_a), 0);
    repeat (5) @(negedge clk);
    chk("hold_cx_a", 32'(cx_a), 7);
    chk("hold_cy_a", 32'(cy_a), 5);
    chk("hold_cover_a", 32'(cov_a), 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
